// File: rtl/otter_io_hub.sv
// otter_io_hub: memory-mapped IO hub for the OTTER MCU.
// Provides switch input (synchronized, optionally debounced), LED and
// seven-segment output registers, and a masked, write-1-to-clear interrupt
// pending register that flags every change of a debounced switch bit.
// Optional feature: define OTTER_IO_HUB_DEBOUNCE_EN to build the per-bit
// debouncer; without it the debounced value is the synchronizer output.
module otter_io_hub #(
  parameter logic [31:0] BASE_AD         = 32'h11000000,
  parameter int          N_LED           = 2,
  parameter int          SW_W            = 16,
  parameter int          DEBOUNCE_CYCLES = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [31:0]          IOBUS_ADDR,
  input  logic [31:0]          IOBUS_OUT,
  input  logic                 IOBUS_WR,
  output logic [31:0]          IOBUS_IN,
  input  logic [SW_W-1:0]      SWITCHES,
  output logic [16*N_LED-1:0]  LEDS,
  output logic [15:0]          SSEG,
  output logic                 INTR
);

  localparam logic [31:0] SW_AD   = BASE_AD;
  localparam logic [31:0] LED_AD  = BASE_AD + 32'h20;
  localparam logic [31:0] SSEG_AD = BASE_AD + 32'h40;
  localparam logic [31:0] PEND_AD = BASE_AD + 32'h60;
  localparam logic [31:0] MASK_AD = BASE_AD + 32'h64;

  logic [N_LED-1:0][15:0] led;
  logic [15:0]            sseg;
  logic [15:0]            mask;
  logic [SW_W-1:0]        pend;
  logic [SW_W-1:0]        sync1, sync2;
  logic [SW_W-1:0]        deb, deb_prev;
  logic [N_LED-1:0]       led_we;
  logic                   sseg_we, pend_we, mask_we;
  logic [31:0]            rdata;

  // Write-enable decode: exact word address match qualified by the strobe.
  always_comb begin
    // NOTE: combinational blocks give every output a default first so no latch is inferred.
    led_we  = '0;
    sseg_we = IOBUS_WR && (IOBUS_ADDR == SSEG_AD);
    pend_we = IOBUS_WR && (IOBUS_ADDR == PEND_AD);
    mask_we = IOBUS_WR && (IOBUS_ADDR == MASK_AD);
    for (int i = 0; i < N_LED; i++)
      led_we[i] = IOBUS_WR && (IOBUS_ADDR == LED_AD + 32'(4 * i));
  end

  // Two-flop synchronizer for the raw switch pins.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      // NOTE: non-blocking assignments so sync2 takes the old sync1, forming two real stages.
      sync1 <= SWITCHES;
      sync2 <= sync1;
    end
  end

`ifdef OTTER_IO_HUB_DEBOUNCE_EN
  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_W-1:0][CNT_W-1:0] cnt;

  // Per-bit debounce: count while input disagrees, toggle on the terminal count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < SW_W; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_MAX) begin
            deb[i] <= ~deb[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign deb = sync2;
`endif

  // Change detector on the debounced value plus the pending/mask registers;
  // a new change wins over a simultaneous W1C of the same bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      deb_prev <= '0;
      pend     <= '0;
      mask     <= '0;
    end else begin
      deb_prev <= deb;
      pend     <= (pend & ~(pend_we ? IOBUS_OUT[SW_W-1:0] : '0)) | (deb ^ deb_prev);
      if (mask_we) mask <= IOBUS_OUT[15:0];
    end
  end

  // LED and seven-segment output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the LED array is a bank of flops, not a RAM, so it can and must be reset.
      led  <= '0;
      sseg <= '0;
    end else begin
      for (int i = 0; i < N_LED; i++)
        if (led_we[i]) led[i] <= IOBUS_OUT[15:0];
      if (sseg_we) sseg <= IOBUS_OUT[15:0];
    end
  end

  // Read mux: zero-extended register contents, unmapped addresses read 0.
  always_comb begin
    rdata = '0;
    if (IOBUS_ADDR == SW_AD)   rdata = 32'(deb);
    if (IOBUS_ADDR == SSEG_AD) rdata = {16'h0, sseg};
    if (IOBUS_ADDR == PEND_AD) rdata = 32'(pend);
    if (IOBUS_ADDR == MASK_AD) rdata = {16'h0, mask};
    for (int i = 0; i < N_LED; i++)
      if (IOBUS_ADDR == LED_AD + 32'(4 * i)) rdata = {16'h0, led[i]};
  end

  assign IOBUS_IN = rdata;
  assign LEDS     = led;
  assign SSEG     = sseg;
  assign INTR     = |(pend & mask[SW_W-1:0]);

  // Upper write-data bits are never stored; the debounce length only matters
  // when the debouncer is built.
  logic unused;
  assign unused = &{1'b0, IOBUS_OUT[31:16], mask, 32'(DEBOUNCE_CYCLES)};

endmodule

// File: tb/tb_otter_io_hub.sv
// tb_otter_io_hub: directed self-checking bench for otter_io_hub
// (N_LED=2, SW_W=16, DEBOUNCE_CYCLES=8). Expected switch latency follows
// OTTER_IO_HUB_DEBOUNCE_EN.
module tb_otter_io_hub;

`ifdef OTTER_IO_HUB_DEBOUNCE_EN
  localparam int          LAT       = 10;
  localparam logic [31:0] PEND_BASE = 32'h0;
`else
  localparam int          LAT       = 2;
  localparam logic [31:0] PEND_BASE = 32'h20;
`endif

  localparam logic [31:0] A_SW   = 32'h11000000;
  localparam logic [31:0] A_LED0 = 32'h11000020;
  localparam logic [31:0] A_LED1 = 32'h11000024;
  localparam logic [31:0] A_LED2 = 32'h11000028;
  localparam logic [31:0] A_SSEG = 32'h11000040;
  localparam logic [31:0] A_PEND = 32'h11000060;
  localparam logic [31:0] A_MASK = 32'h11000064;
  localparam logic [31:0] A_BAD  = 32'h11000080;

  logic        clk;
  logic        rst_n;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  logic [15:0] switches;
  logic [31:0] leds;
  logic [15:0] sseg;
  logic        intr;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;

  otter_io_hub #(
    .BASE_AD(32'h11000000), .N_LED(2), .SW_W(16), .DEBOUNCE_CYCLES(8)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .IOBUS_ADDR(iobus_addr), .IOBUS_OUT(iobus_out),
    .IOBUS_WR(iobus_wr), .IOBUS_IN(iobus_in), .SWITCHES(switches),
    .LEDS(leds), .SSEG(sseg), .INTR(intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
    iobus_addr = addr;
    iobus_out  = data;
    iobus_wr   = 1'b1;
    tick();
    iobus_wr   = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
    iobus_addr = addr;
    #1;
    data = iobus_in;
  endtask

  initial begin
    rst_n      = 1'b0;
    iobus_addr = '0;
    iobus_out  = '0;
    iobus_wr   = 1'b0;
    switches   = '0;
    #12;

    // Reset state
    check("rst_leds", leds, 32'h0);
    check("rst_sseg", 32'(sseg), 32'h0);
    check("rst_intr", 32'(intr), 32'h0);
    read_reg(A_SW, rd);   check("rst_sw", rd, 32'h0);
    read_reg(A_PEND, rd); check("rst_pend", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // LED channel 1: only low 16 bits stored, channel 0 untouched
    write_reg(A_LED1, 32'hDEADBEEF);
    check("led1_out", 32'(leds[31:16]), 32'h0000BEEF);
    check("led0_untouched", 32'(leds[15:0]), 32'h0);
    read_reg(A_LED1, rd); check("led1_read", rd, 32'h0000BEEF);

    // Ignored writes: nonexistent LED channel, unmapped, read-only SW
    write_reg(A_LED2, 32'h00001234);
    write_reg(A_BAD, 32'h00005555);
    write_reg(A_SW, 32'h0000FFFF);
    check("ignored_leds", leds, 32'hBEEF0000);
    read_reg(A_LED2, rd); check("led2_read", rd, 32'h0);
    read_reg(A_BAD, rd);  check("bad_read", rd, 32'h0);
    read_reg(A_SW, rd);   check("sw_ro", rd, 32'h0);
    read_reg(A_PEND, rd); check("pend_clean", rd, 32'h0);

    // SSEG and LED channel 0
    write_reg(A_SSEG, 32'hFFFFA5A5);
    check("sseg_out", 32'(sseg), 32'h0000A5A5);
    read_reg(A_SSEG, rd); check("sseg_read", rd, 32'h0000A5A5);
    write_reg(A_LED0, 32'h00001111);
    check("led0_out", leds, 32'hBEEF1111);

`ifdef OTTER_IO_HUB_DEBOUNCE_EN
    // Short pulse must be filtered out completely
    switches = 16'h0008;
    repeat (5) tick();
    switches = 16'h0000;
    repeat (20) tick();
    read_reg(A_SW, rd);   check("pulse_sw", rd, 32'h0);
    read_reg(A_PEND, rd); check("pulse_pend", rd, 32'h0);
    // Held switch: visible after exactly 10 cycles, pending one later
    switches = 16'h0008;
    repeat (9) tick();
    read_reg(A_SW, rd);   check("db_sw_9", rd, 32'h0);
    tick();
    read_reg(A_SW, rd);   check("db_sw_10", rd, 32'h00000008);
    read_reg(A_PEND, rd); check("db_pend_10", rd, 32'h0);
    tick();
    read_reg(A_PEND, rd); check("db_pend_11", rd, 32'h00000008);
`else
    // Latency exactly 2 cycles, pending one cycle later
    switches = 16'h0008;
    tick();
    read_reg(A_SW, rd);   check("sw_lat1", rd, 32'h0);
    tick();
    read_reg(A_SW, rd);   check("sw_lat2", rd, 32'h00000008);
    read_reg(A_PEND, rd); check("pend_lat2", rd, 32'h0);
    tick();
    read_reg(A_PEND, rd); check("pend_lat3", rd, 32'h00000008);
    // One-cycle glitch on bit 5 still reaches PEND
    switches = 16'h0028;
    tick();
    switches = 16'h0008;
    repeat (4) tick();
    read_reg(A_PEND, rd); check("glitch_pend", rd, 32'h00000028);
`endif

    // Mask enables the already-pending bit 3
    check("intr_unmasked", 32'(intr), 32'h0);
    write_reg(A_MASK, 32'h00000008);
    check("intr_masked", 32'(intr), 32'h1);
    read_reg(A_MASK, rd); check("mask_read", rd, 32'h00000008);

    // W1C of bit 3 drops INTR on that edge
    write_reg(A_PEND, 32'h00000008);
    check("w1c_intr", 32'(intr), 32'h0);
    read_reg(A_PEND, rd); check("w1c_pend", rd, PEND_BASE);

    // New change of bit 3 coincident with a W1C of bit 3: stays set
    switches = 16'h0000;
    repeat (LAT) tick();
    write_reg(A_PEND, 32'h00000008);
    read_reg(A_PEND, rd); check("coincident_pend", rd, PEND_BASE | 32'h8);
    check("coincident_intr", 32'(intr), 32'h1);

    // Asynchronous reset mid-operation
    write_reg(A_LED0, 32'h0000FFFF);
    check("led0_ffff", leds, 32'hBEEFFFFF);
    #2;
    rst_n    = 1'b0;
    switches = 16'h0008;
    #1;
    check("async_leds", leds, 32'h0);
    check("async_sseg", 32'(sseg), 32'h0);
    check("async_intr", 32'(intr), 32'h0);
    read_reg(A_PEND, rd); check("async_pend", rd, 32'h0);
    read_reg(A_MASK, rd); check("async_mask", rd, 32'h0);

    // Switch already high at reset release reports as a change
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT - 1) tick();
    read_reg(A_SW, rd);   check("rel_sw_early", rd, 32'h0);
    tick();
    read_reg(A_SW, rd);   check("rel_sw", rd, 32'h00000008);
    tick();
    read_reg(A_PEND, rd); check("rel_pend", rd, 32'h00000008);
    check("rel_intr", 32'(intr), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otter_io_hub.md
OTTER_IO_HUB -- requirements
Module: otter_io_hub

Interface
REQ-001 Parameters SHALL be, one per line:
- BASE_AD, 32'h11000000, base of the decoded IO window.
- N_LED, 2, number of 16-bit LED output channels, 1..4.
- SW_W, 16, switch input width, 1..16.
- DEBOUNCE_CYCLES, 8, required stable cycles per switch bit, >=2.
REQ-002 Ports SHALL be, one per line:
- CLK, in, 1, single clock.
- RST_N, in, 1, asynchronous active-low reset.
- IOBUS_ADDR, in, 32, bus address.
- IOBUS_OUT, in, 32, CPU write data.
- IOBUS_WR, in, 1, write strobe.
- IOBUS_IN, out, 32, read data.
- SWITCHES, in, SW_W, raw asynchronous switch pins.
- LEDS, out, 16*N_LED, LED channels; channel i occupies bits [16i+15:16i].
- SSEG, out, 16, seven-segment data word.
- INTR, out, 1, interrupt request to MCU.
REQ-003 The block SHALL use one clock, CLK; RST_N SHALL be asynchronous and active-low; all flops SHALL be in the CLK domain.

Function
REQ-004 Address map, all word-aligned offsets from BASE_AD:
- 0x00: SW, RO.
- 0x20+4i: LED_i, RW, i<N_LED.
- 0x40: SSEG, RW.
- 0x60: IRQ_PEND, RO with W1C.
- 0x64: IRQ_MASK, RW.
REQ-005 Writes SHALL take effect on the CLK edge where IOBUS_WR=1 and the address matches; only bits [15:0] are stored, and the outputs update that same edge.
REQ-006 Writes to unmapped addresses, to SW, or to LED_i with i>=N_LED SHALL be ignored.
REQ-007 IOBUS_IN SHALL be combinational from IOBUS_ADDR and registered state, zero-extended to 32 bits; unmapped addresses SHALL read 0.
REQ-008 RW registers SHALL read back their last written value.
REQ-009 Each SWITCHES bit SHALL pass a 2-flop synchronizer before any other use.
REQ-010 Debounce (when enabled): per bit, a counter SHALL increment while the synchronized value differs from the debounced value, and clear when they match.
REQ-011 The debounced bit SHALL toggle on the edge where its counter reaches DEBOUNCE_CYCLES-1; the counter SHALL then clear.
REQ-012 A pulse shorter than DEBOUNCE_CYCLES cycles SHALL never change the debounced value.
REQ-013 Any change of a debounced bit SHALL set IRQ_PEND[bit] on the following edge.
REQ-014 A W1C write SHALL clear the addressed PEND bits written as 1.
REQ-015 Simultaneous set and clear of the same PEND bit SHALL leave it set.
REQ-016 INTR SHALL equal OR(IRQ_PEND & IRQ_MASK), driven directly from registers with no bus-path combinational input.
REQ-017 Setting a mask bit while its pending bit is already 1 SHALL assert INTR after that edge.

Reset
REQ-018 On RST_N=0, all of the following SHALL clear asynchronously to 0: LEDS, SSEG, IRQ_PEND, IRQ_MASK, synchronizer flops, debounced values, counters; INTR SHALL be 0.
REQ-019 Reset deassertion SHALL be honoured on the next CLK edge.
REQ-020 A switch already high at reset release SHALL be reported as a change, setting PEND, after normal latency.
REQ-021 Reset mid-debounce SHALL discard partial counts.

Configuration
REQ-022 With macro OTTER_IO_HUB_DEBOUNCE_EN defined, the debouncer of REQ-010..REQ-012 SHALL be compiled in, and SW latency is 2+DEBOUNCE_CYCLES cycles.
REQ-023 With OTTER_IO_HUB_DEBOUNCE_EN undefined, the debounced value SHALL equal the synchronizer output, latency 2 cycles, no counters instantiated; REQ-013 SHALL still apply.

Verification
REQ-024 The bench SHALL cover, with N_LED=2 and DEBOUNCE_CYCLES=8:
- Write 0xBEEF to 0x11000024 -> LEDS[31:16]=0xBEEF next edge; read 0x11000024 returns 0x0000BEEF; LEDS[15:0] stays 0.
- Write to 0x11000028 (i=2) and 0x11000080 -> no state change; reads of both return 0.
- SWITCHES[3] high for 5 cycles, then low -> SW and IRQ_PEND stay 0. SWITCHES[3] held high -> SW reads 0x0008 after 10 cycles and IRQ_PEND[3]=1 one cycle later.
- IRQ_MASK=0x0008 with PEND[3]=1 -> INTR=1. W1C write of 0x0008 -> INTR=0 next edge. A new change coincident with that write -> PEND[3] stays 1.
- RST_N pulsed low mid-operation with LEDS=0xFFFF -> LEDS, SSEG, and INTR go 0 immediately, without a clock edge.
- Macro undefined -> SW latency is exactly 2 cycles, and a 1-cycle glitch sets PEND.
